// File: rtl/apu_pkg.sv
// apu_pkg: types and constants shared by the APU sound channels.
package apu_pkg;

  localparam int DEF_FREQ_W = 11;
  localparam int DEF_LEN_W  = 6;
  localparam int DEF_VOL_W  = 4;
  localparam int DEF_ENV_W  = 3;

  typedef enum logic [1:0] {
    DUTY_12 = 2'b00,
    DUTY_25 = 2'b01,
    DUTY_50 = 2'b10,
    DUTY_75 = 2'b11
  } duty_t;

  // One 8-step waveform per duty setting; the leftmost bit is step 0.
  localparam logic [3:0][7:0] DUTY_TABLE = {
    8'b01111110,
    8'b10000111,
    8'b10000001,
    8'b00000001
  };

  function automatic logic duty_level(duty_t sel, logic [2:0] step);
    logic [7:0] pattern;
    pattern = DUTY_TABLE[sel];
    return pattern[3'd7 - step];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// apu_envelope: volume register with a periodic +/-1 step that freezes once
// it hits either end of the range; shared by the pulse and noise channels.
module apu_envelope
  import apu_pkg::*;
#(
  parameter int VOL_W = DEF_VOL_W,
  parameter int ENV_W = DEF_ENV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             trigger,
  input  logic [VOL_W-1:0] init,
  input  logic             up,
  input  logic [ENV_W-1:0] period,
  output logic [VOL_W-1:0] volume
);

  localparam logic [VOL_W-1:0] VOL_MAX = '1;
  localparam logic [VOL_W-1:0] VOL_ONE = {{(VOL_W-1){1'b0}}, 1'b1};
  localparam logic [ENV_W-1:0] ENV_ONE = {{(ENV_W-1){1'b0}}, 1'b1};

  logic [ENV_W-1:0] period_cnt;
  logic             saturated;
  logic             at_limit;

  assign at_limit = up ? (volume == VOL_MAX) : (volume == '0);

  // Trigger restarts the envelope; each expiry of the period counter steps the volume until it saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      volume     <= '0;
      period_cnt <= '0;
      saturated  <= 1'b0;
    end else if (trigger) begin
      volume     <= init;
      period_cnt <= period;
      saturated  <= 1'b0;
    end else if (tick && (period != '0)) begin
      if (period_cnt <= ENV_ONE) begin
        period_cnt <= period;
        if (!saturated) begin
          if (at_limit) begin
            saturated <= 1'b1;
          end else if (up) begin
            volume <= volume + VOL_ONE;
          end else begin
            volume <= volume - VOL_ONE;
          end
        end
      end else begin
        period_cnt <= period_cnt - ENV_ONE;
      end
    end
  end

endmodule

// File: rtl/pulse_channel_gen.sv
// pulse_channel_gen: square-wave voice (divider, duty sequencer, length
// counter, envelope, DAC gating). Define PULSE_SWEEP_EN to add the
// frequency sweep unit and its three control inputs.
module pulse_channel_gen
  import apu_pkg::*;
#(
  parameter int FREQ_W = DEF_FREQ_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int VOL_W  = DEF_VOL_W,
  parameter int ENV_W  = DEF_ENV_W
) (
  input  logic              amuk_4mhz,
  input  logic              napu_reset,
  input  logic              freq_tick,
  input  logic              len_tick,
  input  logic              env_tick,
  input  logic              sweep_tick,
  input  logic [1:0]        duty,
  input  logic              len_load,
  input  logic [LEN_W-1:0]  len_val,
  input  logic              len_en,
  input  logic [VOL_W-1:0]  env_init,
  input  logic              env_up,
  input  logic [ENV_W-1:0]  env_period,
  input  logic [FREQ_W-1:0] freq,
  input  logic              trigger,
`ifdef PULSE_SWEEP_EN
  input  logic [2:0]        sweep_period,
  input  logic              sweep_neg,
  input  logic [2:0]        sweep_shift,
`endif
  output logic              active,
  output logic              dac_en,
  output logic [VOL_W-1:0]  ch_out,
  output logic [FREQ_W-1:0] freq_cur
);

  localparam logic [LEN_W:0]    LEN_FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]    LEN_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [FREQ_W-1:0] FREQ_ONE = {{(FREQ_W-1){1'b0}}, 1'b1};

  logic [FREQ_W-1:0] div_cnt;
  logic [2:0]        step;
  logic [LEN_W:0]    len_cnt;
  logic [LEN_W:0]    len_next;
  logic              len_expire;
  logic [VOL_W-1:0]  volume;
  logic [VOL_W-1:0]  out_q;
  logic              sweep_kill;

  assign dac_en = (env_init != '0) || env_up;
  assign ch_out = dac_en ? out_q : '0;

  apu_envelope #(
    .VOL_W (VOL_W),
    .ENV_W (ENV_W)
  ) u_envelope (
    .clk     (amuk_4mhz),
    .rst_n   (napu_reset),
    .tick    (env_tick),
    .trigger (trigger),
    .init    (env_init),
    .up      (env_up),
    .period  (env_period),
    .volume  (volume)
  );

  // Length next value: a write lands first so a same-cycle trigger sees it; trigger blocks the tick.
  always_comb begin
    len_next   = len_cnt;
    len_expire = 1'b0;
    if (len_load) begin
      len_next = LEN_FULL - {1'b0, len_val};
    end else if (!trigger && len_tick && len_en && (len_cnt != '0)) begin
      len_next   = len_cnt - LEN_ONE;
      len_expire = (len_cnt == LEN_ONE);
    end
    if (trigger && (len_next == '0)) begin
      len_next = LEN_FULL;
    end
  end

`ifdef PULSE_SWEEP_EN
  logic [FREQ_W-1:0] shadow;
  logic [FREQ_W-1:0] sweep_base;
  logic [FREQ_W-1:0] sweep_delta;
  logic [FREQ_W:0]   sweep_sum;
  logic [2:0]        sweep_cnt;
  logic              sweep_expire;

  assign sweep_base   = trigger ? freq : shadow;
  assign sweep_delta  = sweep_base >> sweep_shift;
  assign sweep_sum    = sweep_neg ? ({1'b0, sweep_base} - {1'b0, sweep_delta})
                                  : ({1'b0, sweep_base} + {1'b0, sweep_delta});
  assign sweep_expire = !trigger && sweep_tick && (sweep_period != 3'd0) && (sweep_cnt <= 3'd1);
  assign sweep_kill   = sweep_sum[FREQ_W] && ((trigger && (sweep_shift != 3'd0)) || sweep_expire);
  assign freq_cur     = shadow;

  // Sweep unit: trigger captures freq into the shadow; each expiry applies the shift unless it overflows.
  always_ff @(posedge amuk_4mhz) begin
    if (!napu_reset) begin
      shadow    <= freq;
      sweep_cnt <= 3'd0;
    end else if (trigger) begin
      shadow    <= freq;
      sweep_cnt <= sweep_period;
    end else if (sweep_tick && (sweep_period != 3'd0)) begin
      if (sweep_cnt <= 3'd1) begin
        sweep_cnt <= sweep_period;
        if (!sweep_sum[FREQ_W] && (sweep_shift != 3'd0)) begin
          shadow <= sweep_sum[FREQ_W-1:0];
        end
      end else begin
        sweep_cnt <= sweep_cnt - 3'd1;
      end
    end
  end
`else
  logic sweep_tick_unused;

  assign sweep_tick_unused = sweep_tick;
  assign sweep_kill        = 1'b0;
  assign freq_cur          = freq;
`endif

  // Channel state: run flag, divider, duty step, length counter and the registered sample.
  always_ff @(posedge amuk_4mhz) begin
    if (!napu_reset) begin
      active  <= 1'b0;
      div_cnt <= '0;
      step    <= 3'd0;
      len_cnt <= '0;
      out_q   <= '0;
    end else begin
      out_q   <= (active && duty_level(duty_t'(duty), step)) ? volume : '0;
      len_cnt <= len_next;
      if (trigger) begin
        active <= dac_en && !sweep_kill;
      end else begin
        active <= active && dac_en && !len_expire && !sweep_kill;
      end
      if (trigger) begin
        div_cnt <= freq_cur;
      end else if (freq_tick) begin
        if (&div_cnt) begin
          div_cnt <= freq_cur;
          step    <= step + 3'd1;
        end else begin
          div_cnt <= div_cnt + FREQ_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_channel_gen.sv
// tb_pulse_channel_gen: directed and randomized checks of the pulse channel
// against a cycle-level behavioural model; PULSE_SWEEP_EN adds sweep checks.
module tb_pulse_channel_gen;

  localparam int FREQ_W   = 11;
  localparam int LEN_W    = 6;
  localparam int VOL_W    = 4;
  localparam int ENV_W    = 3;
  localparam int FREQ_MAX = (1 << FREQ_W) - 1;
  localparam int LEN_MAX  = 1 << LEN_W;
  localparam int VOL_MAX  = (1 << VOL_W) - 1;

  logic              clk = 1'b0;
  logic              napu_reset;
  logic              freq_tick, len_tick, env_tick, sweep_tick;
  logic [1:0]        duty;
  logic              len_load;
  logic [LEN_W-1:0]  len_val;
  logic              len_en;
  logic [VOL_W-1:0]  env_init;
  logic              env_up;
  logic [ENV_W-1:0]  env_period;
  logic [FREQ_W-1:0] freq;
  logic              trigger;
`ifdef PULSE_SWEEP_EN
  logic [2:0]        sweep_period;
  logic              sweep_neg;
  logic [2:0]        sweep_shift;
`endif
  logic              active, dac_en;
  logic [VOL_W-1:0]  ch_out;
  logic [FREQ_W-1:0] freq_cur;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Model state: plain integers following the channel's rules.
  int m_active, m_len, m_vol, m_env_cnt, m_env_sat, m_div, m_step, m_out;
  int m_shadow, m_sweep_cnt;
  int mc_dac, mc_cur, mc_next_out, mc_len_hit, mc_kill, mc_nf;
  int e_dac;

  // Waveforms written step 0 .. step 7.
  int duty_wave [4][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 1},
    '{1, 0, 0, 0, 0, 0, 0, 1},
    '{1, 0, 0, 0, 0, 1, 1, 1},
    '{0, 1, 1, 1, 1, 1, 1, 0}
  };

  pulse_channel_gen #(
    .FREQ_W (FREQ_W),
    .LEN_W  (LEN_W),
    .VOL_W  (VOL_W),
    .ENV_W  (ENV_W)
  ) dut (
    .amuk_4mhz    (clk),
    .napu_reset   (napu_reset),
    .freq_tick    (freq_tick),
    .len_tick     (len_tick),
    .env_tick     (env_tick),
    .sweep_tick   (sweep_tick),
    .duty         (duty),
    .len_load     (len_load),
    .len_val      (len_val),
    .len_en       (len_en),
    .env_init     (env_init),
    .env_up       (env_up),
    .env_period   (env_period),
    .freq         (freq),
    .trigger      (trigger),
`ifdef PULSE_SWEEP_EN
    .sweep_period (sweep_period),
    .sweep_neg    (sweep_neg),
    .sweep_shift  (sweep_shift),
`endif
    .active       (active),
    .dac_en       (dac_en),
    .ch_out       (ch_out),
    .freq_cur     (freq_cur)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_freq_cur();
`ifdef PULSE_SWEEP_EN
    return m_shadow;
`else
    return int'(freq);
`endif
  endfunction

  // Reference model, advanced on every rising edge from the inputs held across it.
  initial forever begin
    @(posedge clk);
    if (!napu_reset) begin
      m_active = 0; m_len = 0; m_vol = 0; m_env_cnt = 0; m_env_sat = 0;
      m_div = 0; m_step = 0; m_out = 0;
      m_shadow = int'(freq); m_sweep_cnt = 0;
    end else begin
      mc_dac      = ((env_init != 0) || env_up) ? 1 : 0;
      mc_cur      = model_freq_cur();
      mc_next_out = (m_active != 0 && duty_wave[duty][m_step] != 0) ? m_vol : 0;
      mc_len_hit  = 0;
      mc_kill     = 0;
      // length
      if (len_load) m_len = LEN_MAX - int'(len_val);
      else if (!trigger && len_tick && len_en && m_len > 0) begin
        m_len = m_len - 1;
        if (m_len == 0) mc_len_hit = 1;
      end
      if (trigger && m_len == 0) m_len = LEN_MAX;
      // divider and duty step
      if (trigger) m_div = mc_cur;
      else if (freq_tick) begin
        if (m_div == FREQ_MAX) begin
          m_div  = mc_cur;
          m_step = (m_step + 1) % 8;
        end else m_div = m_div + 1;
      end
      // envelope
      if (trigger) begin
        m_vol = int'(env_init); m_env_cnt = int'(env_period); m_env_sat = 0;
      end else if (env_tick && env_period != 0) begin
        m_env_cnt = m_env_cnt - 1;
        if (m_env_cnt <= 0) begin
          m_env_cnt = int'(env_period);
          if (m_env_sat == 0) begin
            if (env_up && m_vol < VOL_MAX) m_vol = m_vol + 1;
            else if (!env_up && m_vol > 0) m_vol = m_vol - 1;
            else m_env_sat = 1;
          end
        end
      end
`ifdef PULSE_SWEEP_EN
      if (trigger) begin
        if (sweep_shift != 0 && !sweep_neg &&
            int'(freq) + (int'(freq) >> sweep_shift) > FREQ_MAX) mc_kill = 1;
        m_shadow = int'(freq);
        m_sweep_cnt = int'(sweep_period);
      end else if (sweep_tick && sweep_period != 0) begin
        m_sweep_cnt = m_sweep_cnt - 1;
        if (m_sweep_cnt <= 0) begin
          m_sweep_cnt = int'(sweep_period);
          mc_nf = sweep_neg ? m_shadow - (m_shadow >> sweep_shift)
                            : m_shadow + (m_shadow >> sweep_shift);
          if (mc_nf > FREQ_MAX) mc_kill = 1;
          else if (sweep_shift != 0) m_shadow = mc_nf;
        end
      end
`endif
      if (trigger) m_active = (mc_dac != 0 && mc_kill == 0) ? 1 : 0;
      else m_active = (m_active != 0 && mc_dac != 0 && mc_len_hit == 0 && mc_kill == 0) ? 1 : 0;
      m_out = mc_next_out;
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      e_dac = ((env_init != 0) || env_up) ? 1 : 0;
      check_output("model_active", int'(active), m_active);
      check_output("model_dac_en", int'(dac_en), e_dac);
      check_output("model_ch_out", int'(ch_out), (e_dac != 0) ? m_out : 0);
      check_output("model_freq_cur", int'(freq_cur), model_freq_cur());
    end
  end

  // Advance one edge, then drop all single-cycle strobes.
  task automatic next_cycle();
    @(posedge clk); #1;
    freq_tick = 1'b0; len_tick = 1'b0; env_tick = 1'b0; sweep_tick = 1'b0;
    len_load = 1'b0; trigger = 1'b0;
  endtask

  // Move to just after the falling edge where outputs are stable.
  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic apply_stimulus();
    napu_reset = ($urandom_range(0, 599) != 0);
    freq_tick  = $urandom_range(0, 1) == 1;
    len_tick   = $urandom_range(0, 7) == 0;
    env_tick   = $urandom_range(0, 5) == 0;
    sweep_tick = $urandom_range(0, 5) == 0;
    trigger    = $urandom_range(0, 49) == 0;
    len_load   = $urandom_range(0, 59) == 0;
    len_val    = LEN_W'($urandom);
    if ($urandom_range(0, 29) == 0) duty = 2'($urandom);
    if ($urandom_range(0, 79) == 0) begin
      env_init   = VOL_W'($urandom);
      env_up     = $urandom_range(0, 3) == 0;
      env_period = ENV_W'($urandom);
    end
    if ($urandom_range(0, 99) == 0) len_en = $urandom_range(0, 1) == 1;
    if ($urandom_range(0, 39) == 0)
      freq = ($urandom_range(0, 3) == 0) ? FREQ_W'($urandom) : FREQ_W'($urandom_range(12'h7F0, 12'h7FF));
`ifdef PULSE_SWEEP_EN
    if ($urandom_range(0, 59) == 0) begin
      sweep_period = 3'($urandom);
      sweep_neg    = $urandom_range(0, 1) == 1;
      sweep_shift  = 3'($urandom);
    end
`endif
  endtask

  int exp_wave [8] = '{15, 0, 0, 0, 0, 15, 15, 15};
  int exp_env_dn [3] = '{1, 0, 0};

  initial begin
    // Reset with every strobe asserted.
    napu_reset = 1'b0;
    freq_tick = 1'b1; len_tick = 1'b1; env_tick = 1'b1; sweep_tick = 1'b1;
    len_load = 1'b1; trigger = 1'b1;
    duty = 2'b10; len_val = '0; len_en = 1'b0;
    env_init = 4'hF; env_up = 1'b0; env_period = '0; freq = 11'h123;
`ifdef PULSE_SWEEP_EN
    sweep_period = 3'd0; sweep_neg = 1'b0; sweep_shift = 3'd0;
`endif
    next_cycle();
    check_en = 1'b1;
    settle();
    check_output("reset_active", int'(active), 0);
    check_output("reset_ch_out", int'(ch_out), 0);
    check_output("reset_freq_cur", int'(freq_cur), 32'h123);
    napu_reset = 1'b1;
    next_cycle();

    // Trigger at 50% duty; the step advances every two freq_ticks.
    freq = 11'h7FE; trigger = 1'b1;
    next_cycle();
    settle();
    check_output("trig_active", int'(active), 1);
    next_cycle();
    settle();
    check_output("wave_step0", int'(ch_out), 15);
    for (int s = 1; s <= 8; s++) begin
      freq_tick = 1'b1; next_cycle();
      freq_tick = 1'b1; next_cycle();
      next_cycle();
      settle();
      check_output($sformatf("wave_step%0d", s % 8), int'(ch_out), exp_wave[s % 8]);
    end

    // Length: load 62 with trigger gives two ticks; then an empty counter gives 64.
    len_val = 6'd62; len_en = 1'b1; len_load = 1'b1; trigger = 1'b1;
    next_cycle(); settle();
    check_output("len_start", int'(active), 1);
    len_tick = 1'b1; next_cycle(); settle();
    check_output("len_tick1", int'(active), 1);
    len_tick = 1'b1; next_cycle(); settle();
    check_output("len_tick2", int'(active), 0);
    trigger = 1'b1; next_cycle();
    for (int i = 0; i < 63; i++) begin
      len_tick = 1'b1; next_cycle();
    end
    settle();
    check_output("len_tick63", int'(active), 1);
    len_tick = 1'b1; next_cycle(); settle();
    check_output("len_tick64", int'(active), 0);
    len_en = 1'b0;

    // Envelope down from 2, then up from 0xE.
    env_init = 4'd2; env_up = 1'b0; env_period = 3'd1; trigger = 1'b1;
    next_cycle(); next_cycle(); settle();
    check_output("env_dn_start", int'(ch_out), 2);
    for (int i = 0; i < 3; i++) begin
      env_tick = 1'b1; next_cycle(); next_cycle(); settle();
      check_output($sformatf("env_dn_tick%0d", i + 1), int'(ch_out), exp_env_dn[i]);
    end
    check_output("env_dn_active", int'(active), 1);
    env_init = 4'hE; env_up = 1'b1; trigger = 1'b1;
    next_cycle(); next_cycle(); settle();
    check_output("env_up_start", int'(ch_out), 14);
    env_tick = 1'b1; next_cycle(); next_cycle(); settle();
    check_output("env_up_tick1", int'(ch_out), 15);
    env_tick = 1'b1; next_cycle(); next_cycle(); settle();
    check_output("env_up_tick2", int'(ch_out), 15);

    // DAC off blocks a trigger; switching it off mid-play stops the channel.
    env_init = 4'd0; env_up = 1'b0; env_period = 3'd0; trigger = 1'b1;
    next_cycle(); settle();
    check_output("dac_off_active", int'(active), 0);
    check_output("dac_off_dac_en", int'(dac_en), 0);
    env_init = 4'd5; trigger = 1'b1;
    next_cycle(); next_cycle(); settle();
    check_output("dac_on_ch_out", int'(ch_out), 5);
    env_init = 4'd0; #1;
    check_output("dac_cut_ch_out", int'(ch_out), 0);
    check_output("dac_cut_active", int'(active), 1);
    next_cycle(); settle();
    check_output("dac_cut_next", int'(active), 0);

`ifdef PULSE_SWEEP_EN
    // Sweep: overflow on trigger, then one upward step.
    env_init = 4'hF; freq = 11'h700; sweep_period = 3'd0; sweep_shift = 3'd1; sweep_neg = 1'b0;
    trigger = 1'b1; next_cycle(); settle();
    check_output("sweep_ovf_active", int'(active), 0);
    freq = 11'h100; sweep_period = 3'd1; trigger = 1'b1;
    next_cycle(); settle();
    check_output("sweep_start_active", int'(active), 1);
    check_output("sweep_start_freq", int'(freq_cur), 32'h100);
    sweep_tick = 1'b1; next_cycle(); settle();
    check_output("sweep_step_freq", int'(freq_cur), 32'h180);
`endif

    // Randomized run, checked every cycle by the compare process.
    env_init = 4'hA; env_period = 3'd2; len_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus();
      @(posedge clk); #1;
    end
    napu_reset = 1'b1;
    next_cycle();
    settle();
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
